// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU constants, flag struct and group P/G helper
package alu_pkg;

   localparam int GROUP_W            = 4;
   localparam int SECTION_W          = 16;
   localparam int GROUPS_PER_SECTION = SECTION_W / GROUP_W;

   typedef struct packed {
      logic cout;
      logic ovf;
      logic zero;
      logic neg;
   } alu_flags_t;

   // Returns {BG, BP} for one 4-bit group
   function automatic logic [1:0] group_bg_bp(input logic [GROUP_W-1:0] p,
                                              input logic [GROUP_W-1:0] g);
      logic bg;
      logic bp;
      bg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
      bp = &p;
      return {bg, bp};
   endfunction

endpackage

// File: rtl/cla_carry_unit.sv
// rtl/cla_carry_unit.sv - 16-bit section carry lookahead, 17 carries out
module cla_carry_unit
   import alu_pkg::*;
(
   input  logic [SECTION_W-1:0]          i_p,
   input  logic [SECTION_W-1:0]          i_g,
   input  logic [GROUPS_PER_SECTION-1:0] i_bg,
   input  logic [GROUPS_PER_SECTION-1:0] i_bp,
   input  logic                          i_cin,
   output logic [SECTION_W:0]            o_c
);

   logic [GROUPS_PER_SECTION:0] w_cg;

   // Group carry-ins in flattened lookahead form: no ripple between groups
   always_comb begin
      w_cg[0] = i_cin;
      w_cg[1] = i_bg[0] | (i_bp[0] & i_cin);
      w_cg[2] = i_bg[1] | (i_bp[1] & i_bg[0]) | (i_bp[1] & i_bp[0] & i_cin);
      w_cg[3] = i_bg[2] | (i_bp[2] & i_bg[1]) | (i_bp[2] & i_bp[1] & i_bg[0])
              | (i_bp[2] & i_bp[1] & i_bp[0] & i_cin);
      w_cg[4] = i_bg[3] | (i_bp[3] & i_bg[2]) | (i_bp[3] & i_bp[2] & i_bg[1])
              | (i_bp[3] & i_bp[2] & i_bp[1] & i_bg[0])
              | (i_bp[3] & i_bp[2] & i_bp[1] & i_bp[0] & i_cin);
   end

   // Bit carries ripple only inside a group, seeded by that group's carry-in
   always_comb begin
      logic cc;
      o_c = '0;
      cc  = 1'b0;
      for (int k = 0; k < GROUPS_PER_SECTION; k++) begin
         cc = w_cg[k];
         o_c[k*GROUP_W] = cc;
         for (int i = 0; i < GROUP_W - 1; i++) begin
            cc = i_g[k*GROUP_W+i] | (i_p[k*GROUP_W+i] & cc);
            o_c[k*GROUP_W+i+1] = cc;
         end
      end
      o_c[SECTION_W] = w_cg[GROUPS_PER_SECTION];
   end

endmodule

// File: rtl/cla_add_pipe.sv
// rtl/cla_add_pipe.sv - two-stage pipelined CLA adder/subtractor with valid/ready
module cla_add_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero,
   output logic             neg
);

   localparam int NSEC = WIDTH / SECTION_W;
   localparam int NGRP = WIDTH / GROUP_W;

   logic             w_adv1;
   logic             w_adv2;
   logic [WIDTH-1:0] w_b;
   logic             w_c0;
   logic [WIDTH-1:0] w_p;
   logic [WIDTH-1:0] w_g;
   logic [NGRP-1:0]  w_bg;
   logic [NGRP-1:0]  w_bp;
   logic [WIDTH:0]   w_c;
   logic [NSEC:0]    w_sec_c;
   logic [SECTION_W:0] w_sec_cy [NSEC];
   logic [WIDTH-1:0] w_sum;
   alu_flags_t       w_flags;

   logic             r_v1;
   logic             r_v2;
   logic [WIDTH-1:0] r_p;
   logic [WIDTH-1:0] r_g;
   logic [NGRP-1:0]  r_bg;
   logic [NGRP-1:0]  r_bp;
   logic             r_c0;
   logic [WIDTH-1:0] r_sum;
   alu_flags_t       r_flags;

   assign w_adv2    = r_v1 & (~r_v2 | out_ready);
   assign in_ready  = ~r_v1 | w_adv2;
   assign w_adv1    = in_valid & in_ready;
   assign out_valid = r_v2;

   // Operand conditioning and bit/group propagate-generate for stage 1
   always_comb begin
      logic [1:0] bgbp;
      w_b  = sub ? ~b : b;
      w_c0 = sub ? ~cin : cin;
      w_p  = a ^ w_b;
      w_g  = a & w_b;
      bgbp = 2'b00;
      for (int k = 0; k < NGRP; k++) begin
         bgbp    = group_bg_bp(w_p[k*GROUP_W +: GROUP_W], w_g[k*GROUP_W +: GROUP_W]);
         w_bg[k] = bgbp[1];
         w_bp[k] = bgbp[0];
      end
   end

   assign w_sec_c[0] = r_c0;

   generate
      for (genvar s = 0; s < NSEC; s++) begin : g_sec
         cla_carry_unit u_carry (
            .i_p   (r_p[s*SECTION_W +: SECTION_W]),
            .i_g   (r_g[s*SECTION_W +: SECTION_W]),
            .i_bg  (r_bg[s*GROUPS_PER_SECTION +: GROUPS_PER_SECTION]),
            .i_bp  (r_bp[s*GROUPS_PER_SECTION +: GROUPS_PER_SECTION]),
            .i_cin (w_sec_c[s]),
            .o_c   (w_sec_cy[s])
         );
         assign w_c[s*SECTION_W +: SECTION_W] = w_sec_cy[s][SECTION_W-1:0];
         assign w_sec_c[s+1]                 = w_sec_cy[s][SECTION_W];
      end
   endgenerate

   assign w_c[WIDTH] = w_sec_c[NSEC];

   // Stage 2 result and flags from resolved carries
   always_comb begin
      w_sum        = r_p ^ w_c[WIDTH-1:0];
      w_flags.cout = w_c[WIDTH];
      w_flags.ovf  = w_c[WIDTH] ^ w_c[WIDTH-1];
      w_flags.zero = ~|w_sum;
      w_flags.neg  = w_sum[WIDTH-1];
   end

   // Stage valid bits: fill on advance, drain on handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v1 <= 1'b0;
         r_v2 <= 1'b0;
      end else begin
         r_v1 <= w_adv1 ? 1'b1 : (w_adv2 ? 1'b0 : r_v1);
         r_v2 <= w_adv2 ? 1'b1 : (out_ready ? 1'b0 : r_v2);
      end
   end

   // Stage 1 registers load only when an operand is accepted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_p  <= '0;
         r_g  <= '0;
         r_bg <= '0;
         r_bp <= '0;
         r_c0 <= 1'b0;
      end else if (w_adv1) begin
         r_p  <= w_p;
         r_g  <= w_g;
         r_bg <= w_bg;
         r_bp <= w_bp;
         r_c0 <= w_c0;
      end
   end

   // Stage 2 registers load only when stage 1 advances
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sum   <= '0;
         r_flags <= '0;
      end else if (w_adv2) begin
         r_sum   <= w_sum;
         r_flags <= w_flags;
      end
   end

   assign sum  = r_sum;
   assign cout = r_flags.cout;
   assign ovf  = r_flags.ovf;
   assign zero = r_flags.zero;
   assign neg  = r_flags.neg;

endmodule

// File: tb/tb_cla_add_pipe.sv
// tb/tb_cla_add_pipe.sv - directed self-checking bench for cla_add_pipe
module tb_cla_add_pipe;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        cin;
   logic        sub;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] sum;
   logic        cout;
   logic        ovf;
   logic        zero;
   logic        neg;

   int n_vec;
   int n_err;

   cla_add_pipe #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf),
      .zero      (zero),
      .neg       (neg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: {cout, ovf, zero, neg, sum} via plain 33-bit arithmetic
   function automatic logic [35:0] ref_op(input logic [31:0] ra, input logic [31:0] rb,
                                          input logic rcin, input logic rsub);
      logic [31:0] bb;
      logic [32:0] full;
      logic        v;
      bb   = rsub ? ~rb : rb;
      full = {1'b0, ra} + {1'b0, bb} + {32'd0, (rsub ? ~rcin : rcin)};
      v    = (ra[31] == bb[31]) && (full[31] != ra[31]);
      return {full[32], v, (full[31:0] == 32'd0), full[31], full[31:0]};
   endfunction

   task automatic do_op(input string tag, input logic [31:0] ta, input logic [31:0] tbv,
                        input logic tcin, input logic tsub,
                        input logic [31:0] esum, input logic [3:0] eflg);
      a = ta; b = tbv; cin = tcin; sub = tsub;
      in_valid = 1'b1; out_ready = 1'b1;
      #1;
      chk({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk({tag, " out_valid@N"}, {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;
      chk({tag, " out_valid@N+1"}, {31'd0, out_valid}, 32'd1);
      chk({tag, " sum"}, sum, esum);
      chk({tag, " flags"}, {28'd0, cout, ovf, zero, neg}, {28'd0, eflg});
      @(posedge clk); #1;
      chk({tag, " drained"}, {31'd0, out_valid}, 32'd0);
   endtask

   logic [31:0] sa   [8];
   logic [31:0] sb   [8];
   logic        scin [8];
   logic        ssub [8];
   logic [35:0] e;

   initial begin
      n_vec = 0; n_err = 0;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;

      // Reset state
      @(posedge clk); @(posedge clk); #1;
      chk("rst out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst sum", sum, 32'd0);
      chk("rst flags", {28'd0, cout, ovf, zero, neg}, 32'd0);
      rst_n = 1'b1;
      #1;
      chk("rst in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;

      // Directed arithmetic; flags ordered {cout, ovf, zero, neg}
      do_op("add_sec", 32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 4'b0000);
      do_op("add_ovf", 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 4'b0101);
      do_op("add_wrap", 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 4'b1010);
      do_op("sub_eq", 32'd5, 32'd5, 1'b0, 1'b1, 32'h00000000, 4'b1010);
      do_op("sub_neg", 32'd3, 32'd5, 1'b0, 1'b1, 32'hFFFFFFFE, 4'b0001);
      do_op("sub_bin", 32'd5, 32'd5, 1'b1, 1'b1, 32'hFFFFFFFF, 4'b0001);
      do_op("sub_ovf", 32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 4'b1100);

      // Back-to-back stream of 8 with out_ready held high
      sa[0] = 32'h12345678; sb[0] = 32'h11111111; scin[0] = 1'b0; ssub[0] = 1'b0;
      sa[1] = 32'hFFFF0000; sb[1] = 32'h00010000; scin[1] = 1'b0; ssub[1] = 1'b0;
      sa[2] = 32'h00000010; sb[2] = 32'h00000020; scin[2] = 1'b0; ssub[2] = 1'b1;
      sa[3] = 32'hDEADBEEF; sb[3] = 32'h21524110; scin[3] = 1'b1; ssub[3] = 1'b0;
      sa[4] = 32'h80000000; sb[4] = 32'h80000000; scin[4] = 1'b0; ssub[4] = 1'b0;
      sa[5] = 32'h0000FFFF; sb[5] = 32'h0000FFFF; scin[5] = 1'b1; ssub[5] = 1'b1;
      sa[6] = 32'hAAAAAAAA; sb[6] = 32'h55555555; scin[6] = 1'b1; ssub[6] = 1'b0;
      sa[7] = 32'h00000000; sb[7] = 32'h00000001; scin[7] = 1'b0; ssub[7] = 1'b1;
      for (int j = 0; j < 10; j++) begin
         out_ready = 1'b1;
         if (j < 8) begin
            a = sa[j]; b = sb[j]; cin = scin[j]; sub = ssub[j]; in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (j < 8) chk($sformatf("stream in_ready %0d", j), {31'd0, in_ready}, 32'd1);
         @(posedge clk); #1;
         if (j >= 1 && j <= 8) begin
            e = ref_op(sa[j-1], sb[j-1], scin[j-1], ssub[j-1]);
            chk($sformatf("stream out_valid %0d", j-1), {31'd0, out_valid}, 32'd1);
            chk($sformatf("stream sum %0d", j-1), sum, e[31:0]);
            chk($sformatf("stream flags %0d", j-1), {28'd0, cout, ovf, zero, neg}, {28'd0, e[35:32]});
         end else if (j == 9) begin
            chk("stream drained", {31'd0, out_valid}, 32'd0);
         end
      end

      // Stall: out_ready low 4 cycles with in_valid held, only 2 absorbed
      for (int k = 0; k < 4; k++) begin
         case (k)
            0: begin a = 32'd1;     b = 32'd2;     end
            1: begin a = 32'd10;    b = 32'd20;    end
            2: begin a = 32'h100;   b = 32'h100;   end
            default: begin a = 32'h55; b = 32'd1;  end
         endcase
         cin = 1'b0; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
         #1;
         chk($sformatf("stall in_ready %0d", k), {31'd0, in_ready}, (k < 2) ? 32'd1 : 32'd0);
         if (k >= 2) begin
            chk($sformatf("stall out_valid %0d", k), {31'd0, out_valid}, 32'd1);
            chk($sformatf("stall sum hold %0d", k), sum, 32'd3);
         end
         @(posedge clk); #1;
      end
      chk("stall sum final", sum, 32'd3);
      chk("stall flags final", {28'd0, cout, ovf, zero, neg}, 32'd0);
      in_valid = 1'b0; out_ready = 1'b1;
      #1;
      chk("release in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      chk("drain1 out_valid", {31'd0, out_valid}, 32'd1);
      chk("drain1 sum", sum, 32'h0000001E);
      @(posedge clk); #1;
      chk("drain2 out_valid", {31'd0, out_valid}, 32'd0);

      // Reset with both stages full
      a = 32'd7; b = 32'd8; cin = 1'b0; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("prefill out_valid", {31'd0, out_valid}, 32'd1);
      chk("prefill in_ready", {31'd0, in_ready}, 32'd0);
      rst_n = 1'b0;
      #1;
      chk("midrst out_valid", {31'd0, out_valid}, 32'd0);
      chk("midrst sum", sum, 32'd0);
      chk("midrst flags", {28'd0, cout, ovf, zero, neg}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("postrst no pulse", {31'd0, out_valid}, 32'd0);
      do_op("postrst", 32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 4'b0000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
